// File: rtl/serial_comp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_comp_ctrl_if
// Brief    : Request/result bundle for the sequenced wide comparator.
//            The master drives start and the operands. The slave returns the
//            busy/done handshake and the one-hot eq/gt/lt result.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_comp_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, gt, lt
  );
endinterface
`default_nettype wire

// File: rtl/serial_comp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_comp_ctrl
// Brief    : Sequenced unsigned magnitude comparator. Operands are latched on
//            start and compared 2 bits per cycle, MSB slice first. With
//            EARLY_EXIT the compare stops at the first unequal slice.
//            Otherwise latency is fixed at WIDTH/2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_comp_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  wire                    clk,
  input  wire                    rst_n,
  serial_comp_ctrl_if.slave      bus
);

  localparam int NS = WIDTH / 2;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             diff_q, diff_d;    // a difference has been recorded
  logic             dgt_q, dgt_d;      // recorded difference favours A
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_ne;
  logic             slice_gt;
  logic             res_diff;
  logic             res_gt;
  logic             finish;

  // State and datapath registers; reset clears everything, which also drops
  // busy/done/flags immediately because outputs decode from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      diff_q  <= 1'b0;
      dgt_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      dgt_q   <= dgt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Next-state logic: accept start in IDLE/DONE, walk slices in CMP.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    dgt_d    = dgt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;

    slice_a  = sa_q[WIDTH-1 -: 2];
    slice_b  = sb_q[WIDTH-1 -: 2];
    slice_ne = (slice_a != slice_b);
    slice_gt = (slice_a > slice_b);
    // An earlier recorded difference always dominates the current slice.
    res_diff = diff_q | slice_ne;
    res_gt   = diff_q ? dgt_q : slice_gt;
    finish   = ((EARLY_EXIT != 0) && slice_ne) || (cnt_q == '0);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = CMP;
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = CW'(NS - 1);
          diff_d  = 1'b0;
          dgt_d   = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (slice_ne && !diff_q) begin
          diff_d = 1'b1;
          dgt_d  = slice_gt;
        end
        sa_d  = sa_q << 2;
        sb_d  = sb_q << 2;
        cnt_d = cnt_q - CW'(1);
        if (finish) begin
          state_d = DONE;
          eq_d    = !res_diff;
          gt_d    = res_diff & res_gt;
          lt_d    = res_diff & !res_gt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == CMP);
  assign bus.done = (state_q == DONE);
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_comp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_comp_ctrl
// Brief    : Scoreboard bench for serial_comp_ctrl. The bench instantiates one
//            DUT with early exit and one with fixed latency. Expected flags
//            and done cycles are queued at each start and checked on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_comp_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  typedef struct {
    logic [2:0]  flags;   // {eq, gt, lt}
    int unsigned cyc;     // cycle count at which done must be seen
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;
  exp_t        q1[$];
  exp_t        q0[$];

  serial_comp_ctrl_if #(.WIDTH(W)) if1 ();
  serial_comp_ctrl_if #(.WIDTH(W)) if0 ();

  serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) dut_e1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(0)) dut_e0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [W-1:0] av, input logic [W-1:0] bv);
    if (av == bv)     return 3'b100;
    else if (av > bv) return 3'b010;
    else              return 3'b001;
  endfunction

  // Early-exit latency from the highest differing bit position.
  function automatic int unsigned ee_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] x;
    x = av ^ bv;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) return ((W - 1 - i) / 2) + 1;
    end
    return NS;
  endfunction

  // Called just after a falling edge: the next rising edge is the accept edge.
  task automatic drive(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.flags = model_flags(av, bv);
    e.cyc   = cyc + 1 + (sel ? ee_lat(av, bv) : NS);
    if (sel) begin
      if1.start = 1'b1; if1.a = av; if1.b = bv;
      q1.push_back(e);
    end else begin
      if0.start = 1'b1; if0.a = av; if0.b = bv;
      q0.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q0.size() + q1.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if1.done) begin
        if (q1.size() == 0) check("ee1_spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("ee1_flags", {if1.eq, if1.gt, if1.lt}, e.flags);
          check("ee1_done_cycle", cyc, e.cyc);
        end
      end
      if (if0.done) begin
        if (q0.size() == 0) check("ee0_spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q0.pop_front();
          check("ee0_flags", {if0.eq, if0.gt, if0.lt}, e.flags);
          check("ee0_done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    if0.start = 1'b0; if0.a = '0; if0.b = '0;

    // Reset state
    #23;
    check("rst_e1_outs", {if1.busy, if1.done, if1.eq, if1.gt, if1.lt}, 5'b0);
    check("rst_e0_outs", {if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands, early exit: full NS latency, eq held afterwards
    drive(1, 8'hA5, 8'hA5);
    @(negedge clk);
    if1.start = 1'b0;
    check("eq_busy_after_t0", if1.busy, 1);
    drain();
    check("eq_flags_hold", {if1.done, if1.eq, if1.gt, if1.lt}, 4'b0100);

    // MSB slice differs: early exit vs fixed latency
    drive(1, 8'hC3, 8'h43);
    drive(0, 8'hC3, 8'h43);
    @(negedge clk);
    if1.start = 1'b0; if0.start = 1'b0;
    drain();

    // LSB-only difference, and a recorded difference frozen against later slices
    drive(1, 8'h12, 8'h13);
    drive(0, 8'h80, 8'h7F);
    @(negedge clk);
    if1.start = 1'b0; if0.start = 1'b0;
    drain();

    // Start while busy is ignored; operand changes after accept have no effect
    drive(0, 8'hF0, 8'h0F);
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    if0.start = 1'b1; if0.a = 8'h00; if0.b = 8'hFF;
    @(negedge clk);
    if0.start = 1'b0;
    check("busy_ignore_still_busy", if0.busy, 1);
    if0.a = 8'h3C; if0.b = 8'hC3;
    drain();
    check("busy_ignore_idle", {if0.busy, if0.done}, 2'b00);

    // Reset mid-operation aborts asynchronously with no done pulse
    drive(0, 8'h33, 8'h31);
    drive(1, 8'h00, 8'h01);
    @(negedge clk);
    if0.start = 1'b0; if1.start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_e0_outs", {if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, 5'b0);
    check("midrst_e1_outs", {if1.busy, if1.done, if1.eq, if1.gt, if1.lt}, 5'b0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 8'h01, 8'h02);
    drive(0, 8'h01, 8'h02);
    @(negedge clk);
    if1.start = 1'b0; if0.start = 1'b0;
    drain();

    // Back-to-back: start held through DONE, no IDLE cycle in between
    drive(1, 8'hC3, 8'h43);
    @(negedge clk);                      // CMP (start ignored here)
    @(negedge clk);                      // DONE with gt
    check("b2b_first_done", {if1.done, if1.gt}, 2'b11);
    drive(1, 8'h55, 8'h55);
    @(negedge clk);
    if1.start = 1'b0;
    check("b2b_reaccept", {if1.busy, if1.eq, if1.gt, if1.lt}, 4'b1000);
    drain();

    // A few random operations on both variants
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? ra : W'($urandom_range(0, 255));
      drive(1, ra, rb);
      drive(0, ra, rb);
      @(negedge clk);
      if1.start = 1'b0; if0.start = 1'b0;
      drain();
    end

    check("final_queues_empty", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute run-time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/serial_comp_ctrl.md
Name: serial_comp_ctrl

Overview:
- Sequenced magnitude comparator for wide operands, built around the team's 2-bit comparator slice.
- Latches two WIDTH-bit operands on a start request and compares them 2 bits per cycle, MSB slice first.
- Produces one-hot equal/greater/less flags with a busy/done handshake.
- Serves control logic that needs wide compares without a full-width combinational comparator.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Number of slices NS = WIDTH/2.
- EARLY_EXIT, 1, 1 = finish at the first unequal slice; 0 = always run all NS slices (fixed latency).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled on rising clk.
- a  input  WIDTH  operand A, sampled only when start is accepted.
- b  input  WIDTH  operand B, sampled only when start is accepted.
- busy  output  1  high while in CMP state.
- done  output  1  one-cycle pulse; result flags valid.
- eq  output  1  A == B.
- gt  output  1  A > B (unsigned).
- lt  output  1  A < B (unsigned).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n = 0, state = IDLE and busy = done = eq = gt = lt = 0; shift registers and slice counter are cleared.
- States: IDLE, CMP, DONE. busy = (state == CMP). done = (state == DONE).
- Start acceptance: start is accepted only in IDLE or DONE. Starting from DONE gives back-to-back operation. start in CMP is ignored, with no queueing.
- On the accepting edge T0:
  - a and b load into internal shift registers sa and sb.
  - Slice counter loads NS-1.
  - eq/gt/lt clear to 000.
  - First difference register clears.
  - State -> CMP.
- Each CMP edge compares sa[WIDTH-1:WIDTH-2] against sb[WIDTH-1:WIDTH-2], unsigned 2-bit:
  - If the slices are unequal and no difference is recorded yet, record gt or lt from this slice.
  - Later slices never override a recorded difference.
  - Then shift sa and sb left by 2 (zero fill) and decrement the counter.
- EARLY_EXIT = 1: on the first unequal slice, go to DONE with the flags from that slice. On the slice where counter == 0 with all slices equal, go to DONE with eq = 1.
- EARLY_EXIT = 0: go to DONE only after the counter == 0 slice. Flags = the recorded difference, or eq if none.
- Latency with EARLY_EXIT = 0: done is high in the cycle after edge T0+NS.
- Latency with EARLY_EXIT = 1: done is high after edge T0+k+1, where k is the index of the first differing slice (0 = MSB slice), or T0+NS if the operands are equal.
- eq/gt/lt are updated on the edge entering DONE. Exactly one of them is high. They hold until the next accepted start, which clears them.
- DONE lasts one cycle. It goes to CMP if start = 1, else to IDLE.
- Changes on a and b after T0 have no effect.
- Reset asserted mid-CMP aborts immediately with no done pulse. The first start after reset release behaves normally.
- WIDTH = 2: single CMP cycle; done after T0+1.

Test Plan:
- Equal operands (WIDTH = 8, EARLY_EXIT = 1): a = 0xA5, b = 0xA5, start for 1 cycle -> busy for 4 cycles; done after edge T0+4; eq = 1, gt = 0, lt = 0.
- Early exit on MSB slice (EARLY_EXIT = 1): a = 0xC3, b = 0x43 -> done after edge T0+1; gt = 1. Same stimulus with EARLY_EXIT = 0 -> done after edge T0+4; gt = 1.
- Differ only in LSB slice and freeze check:
  - a = 0x12, b = 0x13 -> done after T0+4; lt = 1.
  - EARLY_EXIT = 0 with a = 0x80, b = 0x7F (later slices favour B) -> gt = 1, lt = 0 at done.
- Start while busy: second start with a = 0x00, b = 0xFF at T0+2 during an a = 0xF0, b = 0x0F compare -> ignored. Single done; gt = 1. a and b toggled mid-operation do not change the result.
- Reset mid-operation: rst_n low at T0+2 -> busy, done and flags go to 0 immediately with no clock edge needed; no done pulse. After release, start with a = 0x01, b = 0x02 -> lt = 1 with normal latency.
- Back-to-back: start held high through the DONE cycle with new operands a = 0x55, b = 0x55 -> done pulses in separate cycles. Flags go to 000 at the second acceptance, then eq = 1; no IDLE cycle in between.
